// File: rtl/line_buf_pkg.sv
// Shared definitions for the binary line buffer and the averaging filter.
// The filter imports column_t so both ends agree on the bit order of a
// vertical column.
package line_buf_pkg;

  localparam int HRES_DEF = 1280;
  localparam int VRES_DEF = 720;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  // One vertical 3-pixel column: [ROW_CUR] newest row, [ROW_UP2] oldest row.
  typedef logic [2:0] column_t;

  localparam int ROW_CUR = 0;
  localparam int ROW_UP1 = 1;
  localparam int ROW_UP2 = 2;

  // Everything a pixel carries while it travels through the first stage.
  typedef struct packed {
    logic                valid;
    logic                pixel;
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
  } stage_t;

  // Row above v, wrapping to the last line of the frame when v is the top row.
  function automatic logic [VCOUNT_W-1:0] prevRow(input logic [VCOUNT_W-1:0] v,
                                                  input int vres);
    if (v == '0) begin
      return VCOUNT_W'(vres - 1);
    end
    return v - VCOUNT_W'(1);
  endfunction

endpackage

// File: rtl/binary_line_ram.sv
// Single-bit line memory: one write port and one read port with a
// registered read (data appears one cycle after rd_en_i). Contents are
// never reset; stale data simply waits to be overwritten.
module binary_line_ram #(
  parameter int DEPTH = 1280,
  parameter int AW    = 11
) (
  input  logic          clk_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          wr_data_i
);

  logic mem_q [DEPTH];
  logic rdData_q;

  // Synchronous write and registered read; a simultaneous read and write
  // always target different addresses within a line, so no bypass exists.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rdData_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/binary_line_buffer.sv
// Line buffer in front of the 3-row binary averaging filter. For every
// accepted pixel it emits the column {row y-2, row y-1, row y} at the same
// hcount, two cycles later, using two single-bit line RAMs that shift rows
// down by one as each pixel passes.
// Optional build macro EDGE_ZERO_PAD_EN: zero the column bits that would
// come from rows above the top of the frame instead of last frame's lines.
module binary_line_buffer
  import line_buf_pkg::*;
#(
  parameter int HRES = HRES_DEF,
  parameter int VRES = VRES_DEF
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                pixel_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                data_valid_in,
  output column_t             data_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                data_valid_out
);

  localparam int AW = (HRES > 1) ? $clog2(HRES) : 1;

  logic                accept;
  logic [AW-1:0]       rdAddr;
  logic [AW-1:0]       wrAddr;
  logic                wrEn;
  logic                line0Rd;
  logic                line1Rd;
  column_t             column;

  stage_t              s1_q, s1_d;
  column_t             dataOut_q, dataOut_d;
  logic [HCOUNT_W-1:0] hcountOut_q, hcountOut_d;
  logic [VCOUNT_W-1:0] vcountOut_q, vcountOut_d;
  logic                validOut_q, validOut_d;

  assign accept = data_valid_in
                  && (hcount_in < HCOUNT_W'(HRES))
                  && (vcount_in < VCOUNT_W'(VRES));
  assign rdAddr = hcount_in[AW-1:0];
  assign wrAddr = s1_q.hcount[AW-1:0];
  assign wrEn   = s1_q.valid && !rst_in;

  // line0 holds row y-1; its old contents fall into line1 (row y-2) on write.
  binary_line_ram #(.DEPTH(HRES), .AW(AW)) uLine0 (
    .clk_i     (clk_in),
    .rd_en_i   (accept),
    .rd_addr_i (rdAddr),
    .rd_data_o (line0Rd),
    .wr_en_i   (wrEn),
    .wr_addr_i (wrAddr),
    .wr_data_i (s1_q.pixel)
  );

  binary_line_ram #(.DEPTH(HRES), .AW(AW)) uLine1 (
    .clk_i     (clk_in),
    .rd_en_i   (accept),
    .rd_addr_i (rdAddr),
    .rd_data_o (line1Rd),
    .wr_en_i   (wrEn),
    .wr_addr_i (wrAddr),
    .wr_data_i (line0Rd)
  );

  // Stage 1 captures the accepted pixel and its coordinates alongside the RAM read.
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = accept;
    if (accept) begin
      s1_d.pixel  = pixel_in;
      s1_d.hcount = hcount_in;
      s1_d.vcount = vcount_in;
    end
  end

  // Assemble the column from RAM read data and the registered pixel.
  always_comb begin
    column          = '0;
    column[ROW_CUR] = s1_q.pixel;
    column[ROW_UP1] = line0Rd;
    column[ROW_UP2] = line1Rd;
`ifdef EDGE_ZERO_PAD_EN
    if (s1_q.vcount == VCOUNT_W'(0)) begin
      column[ROW_UP1] = 1'b0;
      column[ROW_UP2] = 1'b0;
    end else if (s1_q.vcount == VCOUNT_W'(1)) begin
      column[ROW_UP2] = 1'b0;
    end
`endif
  end

  // Stage 2 registers the outputs; the centre row is the row above the input.
  always_comb begin
    validOut_d  = s1_q.valid;
    dataOut_d   = dataOut_q;
    hcountOut_d = hcountOut_q;
    vcountOut_d = vcountOut_q;
    if (s1_q.valid) begin
      dataOut_d   = column;
      hcountOut_d = s1_q.hcount;
      vcountOut_d = prevRow(s1_q.vcount, VRES);
    end
  end

  // Pipeline registers; reset drops any pixels in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_q        <= '0;
      dataOut_q   <= '0;
      hcountOut_q <= '0;
      vcountOut_q <= '0;
      validOut_q  <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      dataOut_q   <= dataOut_d;
      hcountOut_q <= hcountOut_d;
      vcountOut_q <= vcountOut_d;
      validOut_q  <= validOut_d;
    end
  end

  assign data_out       = dataOut_q;
  assign hcount_out     = hcountOut_q;
  assign vcount_out     = vcountOut_q;
  assign data_valid_out = validOut_q;

endmodule

// File: tb/tb_binary_line_buffer.sv
// Self-checking bench for binary_line_buffer with an 8x4 frame. The reference
// keeps, per column, the list of pixels ever accepted there; a column output
// is the current pixel plus the two most recent earlier entries of that list.
// Honors EDGE_ZERO_PAD_EN when the bench is built with it.
module tb_binary_line_buffer;
  import line_buf_pkg::*;

  localparam int H = 8;
  localparam int V = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                pix = 1'b0;
  logic                vin = 1'b0;
  logic [HCOUNT_W-1:0] hc  = '0;
  logic [VCOUNT_W-1:0] vc  = '0;
  column_t             dOut;
  logic [HCOUNT_W-1:0] hOut;
  logic [VCOUNT_W-1:0] vOut;
  logic                vOutV;

  binary_line_buffer #(.HRES(H), .VRES(V)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .pixel_in       (pix),
    .hcount_in      (hc),
    .vcount_in      (vc),
    .data_valid_in  (vin),
    .data_out       (dOut),
    .hcount_out     (hOut),
    .vcount_out     (vOut),
    .data_valid_out (vOutV)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    bit [2:0] data;
    bit [2:0] known;
    int       h;
    int       v;
  } exp_t;

  bit   histQ [H][$];
  exp_t prevExp;
  bit   pendValid;
  int   pendH;
  bit   pendPix;
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Column expected for a pixel accepted now, from the per-column history.
  function automatic exp_t predict(input bit p, input int h, input int v);
    exp_t e;
    int   n;
    e.valid = 1'b1;
    e.h     = h;
    e.v     = (v == 0) ? V - 1 : v - 1;
    e.data  = {2'b00, p};
    e.known = 3'b001;
    n = histQ[h].size();
    if (n >= 1) begin
      e.data[1]  = histQ[h][n-1];
      e.known[1] = 1'b1;
    end
    if (n >= 2) begin
      e.data[2]  = histQ[h][n-2];
      e.known[2] = 1'b1;
    end
`ifdef EDGE_ZERO_PAD_EN
    if (v == 0) begin
      e.data[2:1]  = 2'b00;
      e.known[2:1] = 2'b11;
    end
    if (v <= 1) begin
      e.data[2]  = 1'b0;
      e.known[2] = 1'b1;
    end
`endif
    return e;
  endfunction

  // One clock: drive inputs, advance the model, clock, then check the outputs.
  task automatic applyStimulus(input bit r, input bit val, input bit p, input int h, input int v);
    exp_t cur;
    exp_t due;
    bit   acc;
    cur = '{default: 0};
    acc = val && (h < H) && (v < V) && !r;
    if (acc) cur = predict(p, h, v);
    if (pendValid && !r) histQ[pendH].push_back(pendPix);
    pendValid = 1'b0;
    if (acc) begin
      pendValid = 1'b1;
      pendH     = h;
      pendPix   = p;
    end
    due = prevExp;
    rst = r;
    vin = val;
    pix = p;
    hc  = HCOUNT_W'(h);
    vc  = VCOUNT_W'(v);
    @(posedge clk);
    #1;
    if (r) begin
      checkOutput("rst_valid", 32'(vOutV), 32'(0));
      checkOutput("rst_data", 32'(dOut), 32'(0));
      checkOutput("rst_hcount", 32'(hOut), 32'(0));
      checkOutput("rst_vcount", 32'(vOut), 32'(0));
    end else begin
      checkOutput("valid_out", 32'(vOutV), 32'(due.valid));
      if (due.valid) begin
        checkOutput("data_out", 32'(dOut & due.known), 32'(due.data & due.known));
        checkOutput("hcount_out", 32'(hOut), 32'(due.h));
        checkOutput("vcount_out", 32'(vOut), 32'(due.v));
      end
    end
    prevExp = cur;
  endtask

  initial begin
    bit savedPix;
    prevExp   = '{default: 0};
    pendValid = 1'b0;
    pendH     = 0;
    pendPix   = 1'b0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 2, 1);

    $display("[TB] parity frame");
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H; h++) begin
        applyStimulus(0, 1, 1'(v % 2), h, v);
        if (v == 2 && h == 4) begin
          checkOutput("parity_r2c3_data", 32'(dOut), 32'(3'b010));
          checkOutput("parity_r2c3_h", 32'(hOut), 32'(3));
          checkOutput("parity_r2c3_v", 32'(vOut), 32'(1));
        end
      end
    end

    $display("[TB] all-ones frames");
    for (int f = 0; f < 2; f++) begin
      for (int v = 0; v < V; v++) begin
        for (int h = 0; h < H; h++) begin
          applyStimulus(0, 1, 1, h, v);
          if (f == 1 && h == 1) begin
`ifdef EDGE_ZERO_PAD_EN
            if (v == 0) checkOutput("ones_row0", 32'(dOut), 32'(3'b001));
            if (v == 1) checkOutput("ones_row1", 32'(dOut), 32'(3'b011));
`else
            if (v == 0) checkOutput("ones_row0", 32'(dOut), 32'(3'b111));
            if (v == 1) checkOutput("ones_row1", 32'(dOut), 32'(3'b111));
`endif
            if (v >= 2) checkOutput("ones_row23", 32'(dOut), 32'(3'b111));
          end
        end
      end
    end

    $display("[TB] toggling valid");
    for (int h = 0; h < H; h++) begin
      applyStimulus(0, 1, 1'($urandom_range(0, 1)), h, 0);
      applyStimulus(0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, H - 1), 0);
      if (h == 2) checkOutput("gap_no_valid", 32'(vOutV), 32'(1));
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("gap_idle_valid", 32'(vOutV), 32'(0));
    for (int h = 0; h < H; h++) applyStimulus(0, 1, 1'($urandom_range(0, 1)), h, 1);

    $display("[TB] out-of-range column");
    for (int h = 0; h < H; h++) applyStimulus(0, 1, 1'($urandom_range(0, 1)), h, 2);
    savedPix = histQ[1][histQ[1].size() - 1];
    applyStimulus(0, 1, ~savedPix, 9, 2);
    applyStimulus(0, 1, ~savedPix, 9, 2);
    checkOutput("oor_no_valid", 32'(vOutV), 32'(0));
    applyStimulus(0, 1, 1'($urandom_range(0, 1)), 0, 3);
    applyStimulus(0, 1, 1'($urandom_range(0, 1)), 1, 3);
    applyStimulus(0, 1, 1'($urandom_range(0, 1)), 2, 3);
    checkOutput("oor_ram_kept", 32'(dOut[1]), 32'(savedPix));
    for (int h = 3; h < H; h++) applyStimulus(0, 1, 1'($urandom_range(0, 1)), h, 3);

    $display("[TB] reset mid-line");
    for (int h = 0; h < 4; h++) applyStimulus(0, 1, 1'($urandom_range(0, 1)), h, 0);
    applyStimulus(1, 1, 1, 4, 0);
    for (int h = 5; h < H; h++) applyStimulus(0, 1, 1'($urandom_range(0, 1)), h, 0);
    for (int h = 0; h < H; h++) applyStimulus(0, 1, 1'($urandom_range(0, 1)), h, 1);

    $display("[TB] vcount wrap");
    applyStimulus(0, 1, 1, 5, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap_vcount", 32'(vOut), 32'(V - 1));
    checkOutput("wrap_hcount", 32'(hOut), 32'(5));

    $display("[TB] random raster");
    for (int f = 0; f < 3; f++) begin
      for (int v = 0; v < V; v++) begin
        for (int h = 0; h < H; h++) begin
          while ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 4) == 0)
              applyStimulus(0, 1, 1'($urandom_range(0, 1)), $urandom_range(H, 15), v);
            else
              applyStimulus(0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, H - 1), v);
          end
          applyStimulus(0, 1, 1'($urandom_range(0, 1)), h, v);
        end
      end
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
